// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and
// datapath select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-outputs decoder for the multicycle MIPS controller.
// Moore outputs, with mem_ready/zero gating only where the handshake needs it.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       instr_done_o,
  output logic       illegal_op_o
);

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_en_o      = 1'b0;
    iord_o       = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_B;
    alu_op_o     = ALUOP_ADD;
    pc_src_o     = PCSRC_ALU;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    instr_done_o = 1'b0;
    illegal_op_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_en_o     = mem_ready_i;
      end
      S_DECODE: begin
        // ALU computes PC+4 + (imm<<2) now so BRANCH can use ALUOut.
        alu_src_b_o = SRCB_IMMSH;
        if (!op_supported(opcode_i)) begin
          illegal_op_o = 1'b1;
          instr_done_o = 1'b1;
        end
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o    = 1'b1;
        mem_write_o  = 1'b1;
        iord_o       = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst_o    = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALUOP_SUB;
        pc_src_o     = PCSRC_ALUOUT;
        pc_en_o      = zero_i;
        instr_done_o = 1'b1;
      end
      S_ADDIWB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_JUMP: begin
        pc_src_o     = PCSRC_JUMP;
        pc_en_o      = 1'b1;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register and
// next-state logic; outputs come from mips_ctrl_outdec, enables gated by reset.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] Alu_op,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;

  logic mem_req_raw, mem_write_raw, ir_write_raw, pc_en_raw;
  logic reg_write_raw, instr_done_raw, illegal_op_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i      (state_q),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req_raw),
    .mem_write_o  (mem_write_raw),
    .ir_write_o   (ir_write_raw),
    .pc_en_o      (pc_en_raw),
    .iord_o       (iord),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (Alu_op),
    .pc_src_o     (pc_src),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write_raw),
    .instr_done_o (instr_done_raw),
    .illegal_op_o (illegal_op_raw)
  );

  // Gate enables combinationally so nothing writes after rst_n falls.
  assign mem_req    = rst_n & mem_req_raw;
  assign mem_write  = rst_n & mem_write_raw;
  assign ir_write   = rst_n & ir_write_raw;
  assign pc_en      = rst_n & pc_en_raw;
  assign reg_write  = rst_n & reg_write_raw;
  assign instr_done = rst_n & instr_done_raw;
  assign illegal_op = rst_n & illegal_op_raw;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: driver pushes the expected per-cycle output vector,
// monitor pops and compares on the falling clock edge.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, ir_write, pc_en, iord, alu_src_a;
  logic [1:0] alu_src_b, Alu_op, pc_src;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .Alu_op(Alu_op),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  // Vector: {state, mem_req, mem_write, ir_write, pc_en, iord, alu_src_a,
  //          alu_src_b, Alu_op, pc_src, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op}
  function automatic logic [20:0] ex(input logic r, input state_t st, input logic mr,
                                     input logic z, input logic [5:0] op);
    logic mq, mw, ir, pe, io, sa, rd, m2r, rw, dn, il;
    logic [1:0] sb, ao, ps;
    logic [3:0] s;
    logic legal;
    {mq, mw, ir, pe, io, sa, rd, m2r, rw, dn, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00; s = st;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    if (!r) begin
      s = 4'd0; sb = 2'b01;
    end else begin
      case (st)
        S_FETCH:    begin mq = 1; sb = 2'b01; ir = mr; pe = mr; end
        S_DECODE:   begin sb = 2'b11; il = !legal; dn = !legal; end
        S_MEMADR:   begin sa = 1; sb = 2'b10; end
        S_MEMREAD:  begin mq = 1; io = 1; end
        S_MEMWB:    begin m2r = 1; rw = 1; dn = 1; end
        S_MEMWRITE: begin mq = 1; mw = 1; io = 1; dn = mr; end
        S_EXECUTE:  begin sa = 1; ao = 2'b10; end
        S_ALUWB:    begin rd = 1; rw = 1; dn = 1; end
        S_BRANCH:   begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; dn = 1; end
        S_ADDIEX:   begin sa = 1; sb = 2'b10; end
        S_ADDIWB:   begin rw = 1; dn = 1; end
        S_JUMP:     begin ps = 2'b10; pe = 1; dn = 1; end
        default: ;
      endcase
    end
    return {s, mq, mw, ir, pe, io, sa, sb, ao, ps, rd, m2r, rw, dn, il};
  endfunction

  task automatic step(input logic r, input state_t st, input logic mr,
                      input logic z, input logic [5:0] op);
    rst_n = r; mem_ready = mr; zero = z; opcode = op;
    exp_q.push_back(ex(r, st, mr, z, op));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [20:0] e, got;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {state, mem_req, mem_write, ir_write, pc_en, iord, alu_src_a,
             alu_src_b, Alu_op, pc_src, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cycle%0d outputs got=%06h required=%06h", cyc, got, e);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  initial begin
    @(posedge clk); #1;
    repeat (3) step(0, S_FETCH, 1, 0, LW);
    // lw, 5 cycles
    step(1, S_FETCH, 1, 0, LW);
    step(1, S_DECODE, 1, 0, LW);
    step(1, S_MEMADR, 1, 0, LW);
    step(1, S_MEMREAD, 1, 0, LW);
    step(1, S_MEMWB, 1, 0, LW);
    // sw with 3 wait cycles, preceded by one fetch stall
    step(1, S_FETCH, 0, 0, SW);
    step(1, S_FETCH, 1, 0, SW);
    step(1, S_DECODE, 1, 0, SW);
    step(1, S_MEMADR, 1, 0, SW);
    repeat (3) step(1, S_MEMWRITE, 0, 0, SW);
    step(1, S_MEMWRITE, 1, 0, SW);
    // beq taken and not taken
    step(1, S_FETCH, 1, 1, BEQ);
    step(1, S_DECODE, 1, 1, BEQ);
    step(1, S_BRANCH, 1, 1, BEQ);
    step(1, S_FETCH, 1, 0, BEQ);
    step(1, S_DECODE, 1, 0, BEQ);
    step(1, S_BRANCH, 1, 0, BEQ);
    // R-type, addi, j back-to-back
    step(1, S_FETCH, 1, 0, RT);
    step(1, S_DECODE, 1, 0, RT);
    step(1, S_EXECUTE, 1, 0, RT);
    step(1, S_ALUWB, 1, 0, RT);
    step(1, S_FETCH, 1, 0, ADDI);
    step(1, S_DECODE, 1, 0, ADDI);
    step(1, S_ADDIEX, 1, 0, ADDI);
    step(1, S_ADDIWB, 1, 0, ADDI);
    step(1, S_FETCH, 1, 0, JMP);
    step(1, S_DECODE, 1, 0, JMP);
    step(1, S_JUMP, 1, 0, JMP);
    // illegal opcode
    step(1, S_FETCH, 1, 0, BAD);
    step(1, S_DECODE, 1, 0, BAD);
    // lw stalled in MEMREAD, then reset mid-instruction
    step(1, S_FETCH, 1, 0, LW);
    step(1, S_DECODE, 1, 0, LW);
    step(1, S_MEMADR, 1, 0, LW);
    step(1, S_MEMREAD, 0, 0, LW);
    step(1, S_MEMREAD, 0, 0, LW);
    step(0, S_FETCH, 1, 0, LW);
    step(0, S_FETCH, 1, 0, LW);
    // recovery with a jump
    step(1, S_FETCH, 1, 0, JMP);
    step(1, S_DECODE, 1, 0, JMP);
    step(1, S_JUMP, 1, 0, JMP);
    step(1, S_FETCH, 0, 0, JMP);
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout cycles=%0d required<10000", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
